irq_priority_ctrl: RTL and testbench
====================================

# irq_priority_ctrl

Nested, priority-based interrupt controller for the pipelined CPU. It captures rising edges on external request lines into pending flags and applies per-source masks. It selects the highest-priority eligible source that outranks everything currently in service, and presents it to the CPU with a hold-until-acknowledge handshake. It also tracks in-service nesting until the handler executes `eret`.

## Interface
- N_SRC, 3, number of interrupt sources; index 0 is highest priority.
- VEC_W, 32, width of the handler vector address.
- VEC_BASE, 32'h0000_1000, vector address of source 0.
- VEC_STRIDE, 32'h0000_0010, address step between consecutive source vectors.
- MASK_RST, all ones, reset value of the mask register (1 = source enabled).

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- irq_in  input  N_SRC  raw request lines, already synchronous to clk; rising edges are captured.
- mask_we  input  1  write strobe for the mask register.
- mask_wdata  input  N_SRC  new mask value, written when mask_we=1.
- int_ack  input  1  CPU has taken the presented interrupt; sampled only while int_req=1.
- eret  input  1  one-cycle pulse: the handler has returned.
- int_req  output  1  interrupt request to the CPU.
- int_id  output  clog2(N_SRC)  index of the requested source; valid while int_req=1.
- int_vec  output  VEC_W  handler address, VEC_BASE + int_id*VEC_STRIDE; valid while int_req=1.
- pending  output  N_SRC  captured, not yet acknowledged requests.
- in_service  output  N_SRC  sources whose handlers are active, including nested ones.
- mask  output  N_SRC  current mask register.

## Operation
- **Edge capture:** prev_irq is registered every cycle. A rising edge is irq_in[i]=1 with prev_irq[i]=0, and it sets pending[i].
  - While rst=1, prev_irq loads irq_in, so a line already high when reset releases produces no edge.
  - An edge on an already-pending source is coalesced; no count is kept.
- **Eligibility:** eligible = pending & mask & above, where above[i]=1 iff every in_service bit at index <= i is 0. A source must strictly outrank all active handlers; equal priority never nests.
- **Selection:** the lowest-index eligible bit wins.
- **FSM states:**
  - IDLE: int_req=0. If eligible != 0, latch the winner into int_id and go to REQ.
  - REQ: int_req=1; int_id and int_vec are held stable. On int_ack=1: clear pending[int_id], set in_service[int_id], go to IDLE.
  - REQ is never withdrawn or retargeted. A newly arriving higher-priority source, a mask change, or an eret does not alter int_id while in REQ.
- **eret:** clears the lowest-index set bit of in_service.
  - Ignored when in_service == 0.
  - Accepted in either state.
- **Mask writes:** take effect the cycle after mask_we. Masking does not clear pending; unmasking a pending source makes it eligible.

## Timing
- **Reset values:** int_req=0, int_id=0, int_vec=VEC_BASE, pending=0, in_service=0, mask=MASK_RST, FSM=IDLE. Reset asserted mid-handshake discards the request; no ack is needed.
- **Request latency:** edge sampled at posedge k → pending set after k → int_req=1 after posedge k+1. That is 2 cycles from edge to request.
- **Ack:** int_ack sampled high at posedge m → int_req=0 and in_service updated after m. The FSM spends at least one cycle in IDLE, so the next int_req rises at the earliest after posedge m+1.
- **Simultaneous events:**
  - Edge and ack on the same source in the same cycle: pending stays 1 (the new edge wins). in_service is still set.
  - eret and int_ack in the same cycle: eret clears its bit using the pre-update in_service value, then the ack bit is set.
  - mask_we and a selection in the same cycle: selection uses the old mask.
- int_ack while int_req=0 is ignored.

## Test plan
Configuration for all scenarios: N_SRC=3, VEC_BASE=0x1000, VEC_STRIDE=0x10.

1. **Basic request:** after reset, irq_in=3'b010 → pending=3'b010 one cycle later, then int_req=1, int_id=1, int_vec=0x1010. Ack → in_service=3'b010, pending=0.
2. **Priority:** edges on sources 2 and 0 in the same cycle → int_id=0 (vector 0x1000) first. After ack, source 2 is not eligible. eret → source 2 is requested 2 cycles later with int_vec=0x1020.
3. **Nesting:** in_service=3'b100 and an edge on source 1 → request id 1; ack gives in_service=3'b110. An edge on source 2 is held pending. The first eret leaves in_service=3'b100.
4. **Mask:** mask=3'b110, edge on source 0 → pending=3'b001, no int_req. Write mask=3'b111 → int_req=1 with int_id=0 on the second cycle after the write.
5. **Handshake and corner cases:**
   - int_req held 5 cycles without int_ack → int_id and int_vec stable throughout.
   - Edge on the same source in the ack cycle → pending stays 1.
   - irq_in held high through reset → no pending after reset release.
6. **Reset mid-request:** rst asserted while int_req=1 → next cycle int_req=0, pending=0, in_service=0, mask=3'b111.

Source files
------------

// File: rtl/irq_priority_ctrl.sv
// Nested priority interrupt controller: rising-edge capture, per-source masking,
// strict-outrank selection and a hold-until-acknowledge request handshake.
module irq_priority_ctrl #(
   parameter int unsigned      N_SRC      = 3,
   parameter int unsigned      VEC_W      = 32,
   parameter logic [VEC_W-1:0] VEC_BASE   = VEC_W'(32'h0000_1000),
   parameter logic [VEC_W-1:0] VEC_STRIDE = VEC_W'(32'h0000_0010),
   parameter logic [N_SRC-1:0] MASK_RST   = '1,
   localparam int unsigned     ID_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] irq_in,
   input  logic             mask_we,
   input  logic [N_SRC-1:0] mask_wdata,
   input  logic             int_ack,
   input  logic             eret,
   output logic             int_req,
   output logic [ID_W-1:0]  int_id,
   output logic [VEC_W-1:0] int_vec,
   output logic [N_SRC-1:0] pending,
   output logic [N_SRC-1:0] in_service,
   output logic [N_SRC-1:0] mask
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [N_SRC-1:0] prev_irq_q;
   logic [N_SRC-1:0] pending_q, pending_d;
   logic [N_SRC-1:0] in_service_q, in_service_d;
   logic [N_SRC-1:0] mask_q, mask_d;
   logic [ID_W-1:0]  id_q, id_d;

   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] above;
   logic [N_SRC-1:0] eligible;
   logic [N_SRC-1:0] ack_bit;
   logic [N_SRC-1:0] eret_bit;
   logic [ID_W-1:0]  winner;
   logic             ack_fire;

   // above[i] is set only when no handler at index <= i is active, so equal
   // priority never nests.
   function automatic logic [N_SRC-1:0] outrank_mask(input logic [N_SRC-1:0] isv);
      logic             blocked;
      logic [N_SRC-1:0] m;
      blocked = 1'b0;
      m       = '0;
      for (int i = 0; i < N_SRC; i++) begin
         blocked = blocked | isv[i];
         m[i]    = ~blocked;
      end
      return m;
   endfunction

   function automatic logic [ID_W-1:0] first_set(input logic [N_SRC-1:0] v);
      logic [ID_W-1:0] idx;
      idx = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (v[i]) idx = ID_W'(i);
      end
      return idx;
   endfunction

   function automatic logic [N_SRC-1:0] lowest_bit(input logic [N_SRC-1:0] v);
      return v & (~v + N_SRC'(1));
   endfunction

   function automatic logic [N_SRC-1:0] onehot(input logic [ID_W-1:0] id);
      return N_SRC'(1) << id;
   endfunction

   always_comb begin
      rise     = irq_in & ~prev_irq_q;
      above    = outrank_mask(in_service_q);
      eligible = pending_q & mask_q & above;
      winner   = first_set(eligible);
      ack_bit  = ack_fire ? onehot(id_q) : '0;
      eret_bit = eret ? lowest_bit(in_service_q) : '0;
   end

   // A new edge in the ack cycle re-arms the flag it would otherwise clear.
   always_comb begin
      pending_d    = (pending_q & ~ack_bit) | rise;
      in_service_d = (in_service_q & ~eret_bit) | ack_bit;
      mask_d       = mask_we ? mask_wdata : mask_q;
   end

   // While rst is high this tracks irq_in, so lines already high at release
   // do not look like edges.
   always_ff @(posedge clk) begin
      prev_irq_q <= irq_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q    <= '0;
         in_service_q <= '0;
         mask_q       <= MASK_RST;
         id_q         <= '0;
      end else begin
         pending_q    <= pending_d;
         in_service_q <= in_service_d;
         mask_q       <= mask_d;
         id_q         <= id_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The winner is latched only on leaving IDLE; REQ never retargets.
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      unique case (state_q)
         ST_IDLE: begin
            if (|eligible) begin
               state_d = ST_REQ;
               id_d    = winner;
            end
         end
         ST_REQ: begin
            if (int_ack) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      int_req    = (state_q == ST_REQ);
      ack_fire   = (state_q == ST_REQ) && int_ack;
      int_id     = id_q;
      int_vec    = VEC_BASE + VEC_W'(id_q) * VEC_STRIDE;
      pending    = pending_q;
      in_service = in_service_q;
      mask       = mask_q;
   end

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Scenario bench for irq_priority_ctrl: expected requests are queued as stimulus
// is applied and popped when the controller raises int_req.
module tb_irq_priority_ctrl;

   logic        clk;
   logic        rst;
   logic [2:0]  irq_in;
   logic        mask_we;
   logic [2:0]  mask_wdata;
   logic        int_ack;
   logic        eret;
   logic        int_req;
   logic [1:0]  int_id;
   logic [31:0] int_vec;
   logic [2:0]  pending;
   logic [2:0]  in_service;
   logic [2:0]  mask;

   typedef struct {
      logic [1:0]  id;
      logic [31:0] vec;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   n_checks;
   int   n_fail;
   int   cyc_n;

   irq_priority_ctrl #(
      .N_SRC(3), .VEC_W(32), .VEC_BASE(32'h0000_1000),
      .VEC_STRIDE(32'h0000_0010), .MASK_RST(3'b111)
   ) dut (
      .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we),
      .mask_wdata(mask_wdata), .int_ack(int_ack), .eret(eret),
      .int_req(int_req), .int_id(int_id), .int_vec(int_vec),
      .pending(pending), .in_service(in_service), .mask(mask)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are read on the falling edge.
   task automatic cyc();
      @(negedge clk);
   endtask

   function automatic exp_t mk_exp(input int id);
      exp_t x;
      x.id  = 2'(id);
      x.vec = 32'h0000_1000 + 32'(id) * 32'h0000_0010;
      return x;
   endfunction

   task automatic wait_req(input int budget, output int cycles);
      cycles = -1;
      for (int i = 1; i <= budget; i++) begin
         cyc();
         if (int_req === 1'b1) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic do_reset();
      irq_in = '0; int_ack = 0; eret = 0; mask_we = 0; mask_wdata = '0;
      rst = 1;
      cyc(); cyc();
      rst = 0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      irq_in = '0; int_ack = 0; eret = 0; mask_we = 0; mask_wdata = '0;
      rst = 1;
      cyc(); cyc();
      rst = 0;
      n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL rst_int_req: got %b want 0", int_req); end
      n_checks++; if (int_id !== 2'd0) begin n_fail++; $display("FAIL rst_int_id: got %0d want 0", int_id); end
      n_checks++; if (int_vec !== 32'h1000) begin n_fail++; $display("FAIL rst_int_vec: got %h want 00001000", int_vec); end
      n_checks++; if (pending !== 3'b000) begin n_fail++; $display("FAIL rst_pending: got %b want 000", pending); end
      n_checks++; if (in_service !== 3'b000) begin n_fail++; $display("FAIL rst_in_service: got %b want 000", in_service); end
      n_checks++; if (mask !== 3'b111) begin n_fail++; $display("FAIL rst_mask: got %b want 111", mask); end
   endtask

   task automatic test_basic();
      do_reset();
      irq_in = 3'b010;
      exp_q.push_back(mk_exp(1));
      cyc();
      n_checks++; if (pending !== 3'b010 || int_req !== 1'b0) begin n_fail++; $display("FAIL basic_capture: got pending=%b req=%b want 010/0", pending, int_req); end
      wait_req(4, cyc_n);
      n_checks++; if (cyc_n !== 1) begin n_fail++; $display("FAIL basic_latency: got %0d want 1", cyc_n); end
      n_checks++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL basic_sb: got no expected entry want one"); end
      else begin
         e = exp_q.pop_front();
         if (int_id !== e.id || int_vec !== e.vec) begin n_fail++; $display("FAIL basic_req: got id=%0d vec=%h want id=%0d vec=%h", int_id, int_vec, e.id, e.vec); end
      end
      int_ack = 1; cyc(); int_ack = 0;
      n_checks++; if (int_req !== 1'b0 || in_service !== 3'b010 || pending !== 3'b000) begin n_fail++; $display("FAIL basic_ack: got req=%b isv=%b pend=%b want 0/010/000", int_req, in_service, pending); end
      eret = 1; cyc(); eret = 0;
      n_checks++; if (in_service !== 3'b000) begin n_fail++; $display("FAIL basic_eret: got %b want 000", in_service); end
   endtask

   task automatic test_priority();
      do_reset();
      irq_in = 3'b101;
      exp_q.push_back(mk_exp(0));
      cyc();
      wait_req(4, cyc_n);
      n_checks++;
      if (cyc_n < 0 || exp_q.size() == 0) begin n_fail++; $display("FAIL prio_first: got cycles=%0d want request", cyc_n); end
      else begin
         e = exp_q.pop_front();
         if (int_id !== e.id || int_vec !== e.vec) begin n_fail++; $display("FAIL prio_first: got id=%0d vec=%h want id=%0d vec=%h", int_id, int_vec, e.id, e.vec); end
      end
      int_ack = 1; cyc(); int_ack = 0;
      n_checks++; if (in_service !== 3'b001 || pending !== 3'b100) begin n_fail++; $display("FAIL prio_after_ack: got isv=%b pend=%b want 001/100", in_service, pending); end
      cyc(); cyc(); cyc();
      n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL prio_blocked: got req=%b want 0", int_req); end
      exp_q.push_back(mk_exp(2));
      eret = 1; cyc(); eret = 0;
      n_checks++; if (int_req !== 1'b0 || in_service !== 3'b000) begin n_fail++; $display("FAIL prio_eret: got req=%b isv=%b want 0/000", int_req, in_service); end
      wait_req(4, cyc_n);
      n_checks++;
      if (cyc_n !== 1 || exp_q.size() == 0) begin n_fail++; $display("FAIL prio_second: got cycles=%0d want 1", cyc_n); end
      else begin
         e = exp_q.pop_front();
         if (int_id !== e.id || int_vec !== e.vec) begin n_fail++; $display("FAIL prio_second: got id=%0d vec=%h want id=%0d vec=%h", int_id, int_vec, e.id, e.vec); end
      end
   endtask

   task automatic test_nesting();
      do_reset();
      irq_in = 3'b100;
      exp_q.push_back(mk_exp(2));
      cyc();
      wait_req(4, cyc_n);
      if (cyc_n > 0 && exp_q.size() != 0) e = exp_q.pop_front();
      n_checks++; if (cyc_n < 0 || int_id !== 2'd2) begin n_fail++; $display("FAIL nest_outer: got cycles=%0d id=%0d want id=2", cyc_n, int_id); end
      int_ack = 1; cyc(); int_ack = 0;
      irq_in = 3'b110;
      exp_q.push_back(mk_exp(1));
      cyc();
      wait_req(4, cyc_n);
      n_checks++;
      if (cyc_n !== 1 || exp_q.size() == 0) begin n_fail++; $display("FAIL nest_inner: got cycles=%0d want 1", cyc_n); end
      else begin
         e = exp_q.pop_front();
         if (int_id !== e.id || int_vec !== e.vec) begin n_fail++; $display("FAIL nest_inner: got id=%0d vec=%h want id=%0d vec=%h", int_id, int_vec, e.id, e.vec); end
      end
      int_ack = 1; cyc(); int_ack = 0;
      n_checks++; if (in_service !== 3'b110) begin n_fail++; $display("FAIL nest_isv: got %b want 110", in_service); end
      irq_in = 3'b010; cyc();
      irq_in = 3'b110; cyc();
      cyc(); cyc();
      n_checks++; if (int_req !== 1'b0 || pending !== 3'b100) begin n_fail++; $display("FAIL nest_held: got req=%b pend=%b want 0/100", int_req, pending); end
      eret = 1; cyc(); eret = 0;
      n_checks++; if (in_service !== 3'b100) begin n_fail++; $display("FAIL nest_eret1: got %b want 100", in_service); end
      cyc(); cyc();
      n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL nest_equal: got req=%b want 0", int_req); end
      exp_q.push_back(mk_exp(2));
      eret = 1; cyc(); eret = 0;
      wait_req(4, cyc_n);
      n_checks++;
      if (cyc_n !== 1 || exp_q.size() == 0) begin n_fail++; $display("FAIL nest_release: got cycles=%0d want 1", cyc_n); end
      else begin
         e = exp_q.pop_front();
         if (int_id !== e.id || int_vec !== e.vec) begin n_fail++; $display("FAIL nest_release: got id=%0d vec=%h want id=%0d vec=%h", int_id, int_vec, e.id, e.vec); end
      end
   endtask

   task automatic test_mask();
      do_reset();
      mask_we = 1; mask_wdata = 3'b110; cyc(); mask_we = 0;
      n_checks++; if (mask !== 3'b110) begin n_fail++; $display("FAIL mask_write: got %b want 110", mask); end
      irq_in = 3'b001; cyc();
      cyc(); cyc();
      n_checks++; if (pending !== 3'b001 || int_req !== 1'b0) begin n_fail++; $display("FAIL mask_blocked: got pend=%b req=%b want 001/0", pending, int_req); end
      exp_q.push_back(mk_exp(0));
      mask_we = 1; mask_wdata = 3'b111; cyc(); mask_we = 0;
      n_checks++; if (int_req !== 1'b0 || mask !== 3'b111) begin n_fail++; $display("FAIL mask_old_used: got req=%b mask=%b want 0/111", int_req, mask); end
      cyc();
      n_checks++;
      if (int_req !== 1'b1 || exp_q.size() == 0) begin n_fail++; $display("FAIL mask_unmask: got req=%b want 1", int_req); end
      else begin
         e = exp_q.pop_front();
         if (int_id !== e.id || int_vec !== e.vec) begin n_fail++; $display("FAIL mask_unmask: got id=%0d vec=%h want id=%0d vec=%h", int_id, int_vec, e.id, e.vec); end
      end
   endtask

   task automatic test_hold_corners();
      do_reset();
      irq_in = 3'b010;
      exp_q.push_back(mk_exp(1));
      cyc();
      wait_req(4, cyc_n);
      if (cyc_n > 0 && exp_q.size() != 0) e = exp_q.pop_front();
      // Higher-priority edge, idle eret and mask write arrive while held.
      for (int i = 0; i < 5; i++) begin
         if (i == 1) irq_in = 3'b011;
         eret = (i == 2);
         mask_we = (i == 3); mask_wdata = 3'b101;
         cyc();
         n_checks++; if (int_req !== 1'b1 || int_id !== 2'd1 || int_vec !== 32'h1010) begin n_fail++; $display("FAIL hold_cycle%0d: got req=%b id=%0d vec=%h want 1/1/00001010", i, int_req, int_id, int_vec); end
      end
      mask_we = 0; eret = 0;
      irq_in = 3'b001; cyc();
      irq_in = 3'b011; int_ack = 1; cyc(); int_ack = 0;
      n_checks++; if (pending !== 3'b011 || in_service !== 3'b010) begin n_fail++; $display("FAIL edge_in_ack: got pend=%b isv=%b want 011/010", pending, in_service); end
      exp_q.push_back(mk_exp(0));
      wait_req(4, cyc_n);
      n_checks++;
      if (cyc_n !== 1 || exp_q.size() == 0) begin n_fail++; $display("FAIL nest_over_1: got cycles=%0d want 1", cyc_n); end
      else begin
         e = exp_q.pop_front();
         if (int_id !== e.id || int_vec !== e.vec) begin n_fail++; $display("FAIL nest_over_1: got id=%0d vec=%h want id=%0d vec=%h", int_id, int_vec, e.id, e.vec); end
      end
      int_ack = 1; cyc(); int_ack = 0;
      n_checks++; if (in_service !== 3'b011) begin n_fail++; $display("FAIL nest_over_1_isv: got %b want 011", in_service); end
      irq_in = 3'b111; rst = 1;
      cyc(); cyc();
      rst = 0;
      cyc(); cyc();
      n_checks++; if (pending !== 3'b000 || int_req !== 1'b0) begin n_fail++; $display("FAIL high_thru_reset: got pend=%b req=%b want 000/0", pending, int_req); end
   endtask

   task automatic test_reset_mid_request();
      do_reset();
      mask_we = 1; mask_wdata = 3'b011; cyc(); mask_we = 0;
      irq_in = 3'b010;
      exp_q.push_back(mk_exp(1));
      cyc();
      wait_req(4, cyc_n);
      if (cyc_n > 0 && exp_q.size() != 0) e = exp_q.pop_front();
      int_ack = 1; cyc(); int_ack = 0;
      irq_in = 3'b111;
      exp_q.push_back(mk_exp(0));
      cyc();
      wait_req(4, cyc_n);
      n_checks++;
      if (cyc_n !== 1 || exp_q.size() == 0) begin n_fail++; $display("FAIL midrst_req: got cycles=%0d want 1", cyc_n); end
      else begin
         e = exp_q.pop_front();
         if (int_id !== e.id || pending !== 3'b101 || in_service !== 3'b010) begin n_fail++; $display("FAIL midrst_req: got id=%0d pend=%b isv=%b want %0d/101/010", int_id, pending, in_service, e.id); end
      end
      rst = 1; cyc(); rst = 0;
      n_checks++; if (int_req !== 1'b0 || pending !== 3'b000 || in_service !== 3'b000) begin n_fail++; $display("FAIL midrst_state: got req=%b pend=%b isv=%b want 0/000/000", int_req, pending, in_service); end
      n_checks++; if (mask !== 3'b111 || int_id !== 2'd0 || int_vec !== 32'h1000) begin n_fail++; $display("FAIL midrst_regs: got mask=%b id=%0d vec=%h want 111/0/00001000", mask, int_id, int_vec); end
      cyc();
      n_checks++; if (pending !== 3'b000 || int_req !== 1'b0) begin n_fail++; $display("FAIL midrst_after: got pend=%b req=%b want 000/0", pending, int_req); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clk = 0; rst = 1; irq_in = '0; mask_we = 0; mask_wdata = '0; int_ack = 0; eret = 0;
      n_checks = 0; n_fail = 0;
      test_reset();
      test_basic();
      test_priority();
      test_nesting();
      test_mask();
      test_hold_corners();
      test_reset_mid_request();
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d entries want 0", exp_q.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
